// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use interlock, branch flush, memory wait and
// multi-cycle MDU stall sequencing with a saturating stall-cycle counter.
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_W   = 5,
  parameter int FLUSH_CYCLES = 1,
  parameter int MDU_TIMEOUT  = 64,
  parameter int CNT_W        = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic                  ex_memread,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_br_taken,
  input  logic                  ex_mdu_start,
  input  logic                  mdu_done,
  input  logic                  mem_busy,
  output logic                  pc_write,
  output logic                  ifid_write,
  output logic                  ifid_flush,
  output logic                  idex_write,
  output logic                  idex_flush,
  output logic                  exmem_write,
  output logic                  exmem_bubble,
  output logic [2:0]            hz_state,
  output logic [CNT_W-1:0]      stall_count,
  output logic                  halted
);
  localparam int MAXC = (FLUSH_CYCLES > MDU_TIMEOUT) ? FLUSH_CYCLES : MDU_TIMEOUT;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] FL_LAST  = CW'(FLUSH_CYCLES - 1);
  localparam logic [CW-1:0] MDU_LAST = CW'(MDU_TIMEOUT - 1);

  typedef enum logic [2:0] {
    RUN = 3'd0, MEM_WAIT = 3'd1, FLUSH = 3'd2, MDU_WAIT = 3'd3, HALT = 3'd4
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          load_use;

  // x0 is hardwired zero, so a load targeting it never creates a dependency
  assign load_use = ex_memread && (ex_rd != '0) &&
                    ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));

  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    idex_write   = 1'b1;
    exmem_write  = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    exmem_bubble = 1'b0;
    state_nx     = state;
    cnt_nx       = cnt;
    case (state)
      RUN, MEM_WAIT: begin
        if (mem_busy) begin
          {pc_write, ifid_write, idex_write, exmem_write} = 4'b0;
          state_nx = MEM_WAIT;
        end else if (ex_br_taken) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          state_nx   = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
          cnt_nx     = CW'(1);
        end else if (ex_mdu_start) begin
          {pc_write, ifid_write, idex_write} = 3'b0;
          exmem_bubble = 1'b1;
          state_nx     = MDU_WAIT;
          cnt_nx       = '0;
        end else begin
          if (load_use) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
            idex_flush = 1'b1;
          end
          state_nx = RUN;
        end
      end
      FLUSH: begin
        if (mem_busy) begin
          {pc_write, ifid_write, idex_write, exmem_write} = 4'b0;
        end else begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          cnt_nx     = cnt + CW'(1);
          if (cnt == FL_LAST) state_nx = RUN;
        end
      end
      MDU_WAIT: begin
        if (mdu_done) begin
          state_nx = RUN;
        end else begin
          {pc_write, ifid_write, idex_write} = 3'b0;
          exmem_bubble = 1'b1;
          if (mem_busy) exmem_write = 1'b0;
          cnt_nx = cnt + CW'(1);
          if (cnt == MDU_LAST) state_nx = HALT;
        end
      end
      HALT: {pc_write, ifid_write, idex_write, exmem_write} = 4'b0;
      default: state_nx = RUN;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= RUN;
      cnt         <= '0;
      stall_count <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (!pc_write && stall_count != '1) stall_count <= stall_count + CNT_W'(1);
    end
  end

  assign hz_state = state;
  assign halted   = (state == HALT);
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench: directed scenarios then random stimulus against a
// behavioural model of the hazard rules.
module tb_pipeline_hazard_ctrl;
  localparam int RW = 5, FLC = 2, MTO = 8, CW = 5;

  logic clock = 0, reset = 1;
  logic [RW-1:0] id_rs1, id_rs2, ex_rd;
  logic id_use_rs1, id_use_rs2, ex_memread, ex_br_taken, ex_mdu_start, mdu_done, mem_busy;
  logic pc_write, ifid_write, ifid_flush, idex_write, idex_flush, exmem_write, exmem_bubble, halted;
  logic [2:0] hz_state;
  logic [CW-1:0] stall_count;

  pipeline_hazard_ctrl #(.REG_ADDR_W(RW), .FLUSH_CYCLES(FLC), .MDU_TIMEOUT(MTO), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_memread(ex_memread),
    .ex_rd(ex_rd), .ex_br_taken(ex_br_taken), .ex_mdu_start(ex_mdu_start),
    .mdu_done(mdu_done), .mem_busy(mem_busy), .pc_write(pc_write),
    .ifid_write(ifid_write), .ifid_flush(ifid_flush), .idex_write(idex_write),
    .idex_flush(idex_flush), .exmem_write(exmem_write), .exmem_bubble(exmem_bubble),
    .hz_state(hz_state), .stall_count(stall_count), .halted(halted));

  always #5 clock = ~clock;

  int n_chk = 0, n_err = 0;
  // model: mode 0 run,1 mem wait,2 flushing,3 waiting on MDU,4 halted
  int m_mode, m_flushed, m_age, m_stalls;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic idle();
    {id_rs1, id_rs2, ex_rd} = '0;
    {id_use_rs1, id_use_rs2, ex_memread, ex_br_taken, ex_mdu_start, mdu_done, mem_busy} = '0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1;
    #2;
    chk("rst_state", hz_state, 0);
    chk("rst_writes", {pc_write, ifid_write, idex_write, exmem_write}, 4'hf);
    chk("rst_flush", {ifid_flush, idex_flush, exmem_bubble}, 0);
    chk("rst_count", stall_count, 0);
    chk("rst_halted", halted, 0);
    m_mode = 0; m_flushed = 0; m_age = 0; m_stalls = 0;
    @(negedge clock);
    reset = 0;
    @(posedge clock);
    #1;
  endtask

  // one cycle: predict from rules, compare mid-cycle, advance the model at the edge
  task automatic step();
    bit hold_front, hold_all, hold_mem, flush_front, bubble_id, bubble_mem, lu;
    int nmode, nfl, nage;
    hold_front = 0; hold_all = 0; hold_mem = 0; flush_front = 0; bubble_id = 0; bubble_mem = 0;
    nmode = m_mode; nfl = m_flushed; nage = m_age;
    lu = ex_memread && ex_rd != 0 &&
         ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    if (m_mode == 4) hold_all = 1;
    else if (m_mode == 3) begin
      if (mdu_done) nmode = 0;
      else begin
        hold_front = 1; bubble_mem = 1; hold_mem = mem_busy;
        nage = m_age + 1;
        if (nage == MTO) nmode = 4;
      end
    end else if (m_mode == 2 && mem_busy) hold_all = 1;
    else if (m_mode == 2) begin
      flush_front = 1; bubble_id = 1;
      nfl = m_flushed + 1;
      if (nfl == FLC) nmode = 0;
    end else if (mem_busy) begin
      hold_all = 1; nmode = 1;
    end else if (ex_br_taken) begin
      flush_front = 1; bubble_id = 1;
      nmode = (FLC > 1) ? 2 : 0; nfl = 1;
    end else if (ex_mdu_start) begin
      hold_front = 1; bubble_mem = 1; nmode = 3; nage = 0;
    end else begin
      nmode = 0;
      if (lu) begin
        // only PC and IF/ID hold; ID/EX takes a bubble
        hold_front = 0; bubble_id = 1;
      end
    end
    @(negedge clock);
    chk("pc_write", pc_write, !(hold_all || hold_front || (lu && m_mode < 2 && !mem_busy && !ex_br_taken && !ex_mdu_start)));
    chk("ifid_write", ifid_write, !(hold_all || hold_front || (lu && m_mode < 2 && !mem_busy && !ex_br_taken && !ex_mdu_start)));
    chk("idex_write", idex_write, !(hold_all || hold_front));
    chk("exmem_write", exmem_write, !(hold_all || hold_mem));
    chk("ifid_flush", ifid_flush, flush_front);
    chk("idex_flush", idex_flush, bubble_id);
    chk("exmem_bubble", exmem_bubble, bubble_mem);
    chk("hz_state", hz_state, m_mode);
    chk("halted", halted, m_mode == 4);
    chk("stall_count", stall_count, m_stalls);
    if (!pc_write && m_stalls < (1 << CW) - 1) m_stalls++;
    m_mode = nmode; m_flushed = nfl; m_age = nage;
    @(posedge clock);
    #1;
  endtask

  initial begin
    idle();
    #1;
    do_reset();
    // load-use on rs2
    ex_memread = 1; ex_rd = 5; id_rs2 = 5; id_use_rs2 = 1;
    step(); idle(); step();
    chk("t1_count", stall_count, 1);
    // same but destination is x0
    do_reset();
    ex_memread = 1; ex_rd = 0; id_rs2 = 0; id_use_rs2 = 1;
    step(); idle(); step();
    chk("t2_count", stall_count, 0);
    // two-cycle branch penalty
    do_reset();
    ex_br_taken = 1; step(); ex_br_taken = 0;
    chk("t3_state_flush", hz_state, 2);
    step();
    chk("t3_state_run", hz_state, 0);
    step();
    // MDU finishes on the fifth cycle after start
    do_reset();
    ex_mdu_start = 1; step(); ex_mdu_start = 0;
    repeat (4) step();
    mdu_done = 1; step(); mdu_done = 0; step();
    chk("t4_count", stall_count, 5);
    // MDU timeout then branch ignored while halted
    do_reset();
    ex_mdu_start = 1; step(); ex_mdu_start = 0;
    repeat (MTO) step();
    chk("t5_halted", halted, 1);
    ex_br_taken = 1; step(); step(); ex_br_taken = 0;
    chk("t5_still_halted", halted, 1);
    do_reset();
    // mem_busy outranks branch and load-use, then branch flush on release
    mem_busy = 1; ex_br_taken = 1; ex_memread = 1; ex_rd = 3; id_rs1 = 3; id_use_rs1 = 1;
    step(); step();
    mem_busy = 0; step(); idle(); step(); step();
    // random traffic, occasional asynchronous reset mid-sequence
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 99) < 2) do_reset();
      mem_busy     = ($urandom_range(0, 99) < 20);
      ex_br_taken  = ($urandom_range(0, 99) < 15);
      ex_mdu_start = ($urandom_range(0, 99) < 10);
      ex_memread   = ($urandom_range(0, 99) < 40);
      ex_rd        = RW'($urandom_range(0, 3));
      id_rs1       = RW'($urandom_range(0, 3));
      id_rs2       = RW'($urandom_range(0, 3));
      id_use_rs1   = 1'($urandom_range(0, 1));
      id_use_rs2   = 1'($urandom_range(0, 1));
      mdu_done     = !mem_busy && ($urandom_range(0, 99) < 20);
      step();
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
